// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: FSM encoding, lane geometry
// and the default wait-state count.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_e;

  localparam int LANE_W              = 2;
  localparam int LANES               = 1 << LANE_W;
  localparam int CNT_W               = 4;
  localparam int DEFAULT_WAIT_STATES = 2;

  // Byte accesses touch one lane, word accesses touch all four.
  function automatic logic [LANES-1:0] lane_mask(input logic                byte_acc,
                                                 input logic [LANE_W-1:0] lane);
    return byte_acc ? (LANES'(1) << lane) : {LANES{1'b1}};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 data RAM: synchronous byte-enabled write port and a
// combinational read port sharing one address.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LANES-1:0] be,
  input  logic [AW-1:0]    addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage behind the single-cycle datapath: wait-stated RAM access,
// Stall generation for the PC/architectural writes, and alignment/range faults.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        ByteAccess,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW+1:0]     addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              byte_q, byte_d;
  logic              store_q, store_d;

  logic              req;
  logic              fault;
  logic              commit;
  logic [LANE_W-1:0] lane;
  logic [7:0]        lane_byte;
  logic [31:0]       ram_rdata;

  // Gating with reset keeps Stall low while reset is held even if the
  // controller is still presenting the aborted request.
  assign req    = (MemRead | MemWrite) & reset;
  assign fault  = (!ByteAccess && (ALUResult[1:0] != 2'b00)) ||
                  (ALUResult[31:2] >= 30'(DEPTH_WORDS));
  assign commit = (state_q == ACCESS) && (cnt_q == '0);
  assign lane   = addr_q[LANE_W-1:0];
  assign lane_byte = ram_rdata[{lane, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      byte_q  <= 1'b0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      byte_q  <= byte_d;
      store_q <= store_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    byte_d  = byte_q;
    store_d = store_q;
    case (state_q)
      IDLE: begin
        if (req && !fault) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_STATES);
          addr_d  = ALUResult[AW+1:0];
          wdata_d = WriteData;
          byte_d  = ByteAccess;
          store_d = MemWrite;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          if (!store_q) rdata_d = byte_q ? {24'b0, lane_byte} : ram_rdata;
        end
      end
      // Whatever is on the request lines here belongs to the retiring instruction.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Stall    = (state_q == ACCESS) || ((state_q == IDLE) && req && !fault);
    MemFault = (state_q == IDLE) && req && fault;
    ReadData = rdata_q;
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (commit && store_q),
    .be    (lane_mask(byte_q, lane)),
    .addr  (addr_q[AW+1:2]),
    .wdata (byte_q ? {LANES{wdata_q[7:0]}} : wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (0 and 2 wait states) driven by directed
// steps and random traffic, checked against an array-based memory model.
module tb_dmem_ctrl;

  localparam int DEPTH   = 64;
  localparam int WS [2]  = '{0, 2};

  logic        clk;
  logic        rst_n;
  logic        mr [2];
  logic        mw [2];
  logic        ba [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] rdv [2];
  logic        stv [2];
  logic        mfv [2];

  int errors;
  int checks;

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] rd_m [2];

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk        (clk),
    .reset      (rst_n),
    .MemRead    (mr[0]),
    .MemWrite   (mw[0]),
    .ByteAccess (ba[0]),
    .ALUResult  (addr[0]),
    .WriteData  (wd[0]),
    .ReadData   (rdv[0]),
    .Stall      (stv[0]),
    .MemFault   (mfv[0])
  );

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut2 (
    .clk        (clk),
    .reset      (rst_n),
    .MemRead    (mr[1]),
    .MemWrite   (mw[1]),
    .ByteAccess (ba[1]),
    .ALUResult  (addr[1]),
    .WriteData  (wd[1]),
    .ReadData   (rdv[1]),
    .Stall      (stv[1]),
    .MemFault   (mfv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int s, input logic rd, input logic wr, input logic by,
                       input logic [31:0] a, input logic [31:0] d);
    mr[s]   = rd;
    mw[s]   = wr;
    ba[s]   = by;
    addr[s] = a;
    wd[s]   = d;
  endtask

  task automatic scramble(input int s);
    drive(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, $urandom);
  endtask

  // One instruction's memory access on instance s. hold keeps the request
  // asserted through ACCESS and DONE; otherwise the lines carry noise.
  task automatic op(input int s, input logic rd, input logic wr, input logic by,
                    input logic [31:0] a, input logic [31:0] d, input bit hold);
    logic        fault;
    logic [31:0] prev;
    int          widx;
    int          lane;
    @(negedge clk);
    drive(s, rd, wr, by, a, d);
    #1;
    prev  = rd_m[s];
    fault = (!by && a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
    if (!(rd || wr)) begin
      chk("idle_stall", 32'(stv[s]), 32'd0);
      chk("idle_fault", 32'(mfv[s]), 32'd0);
      chk("idle_rdata", rdv[s], prev);
      return;
    end
    if (fault) begin
      chk("fault_pulse", 32'(mfv[s]), 32'd1);
      chk("fault_stall", 32'(stv[s]), 32'd0);
      @(negedge clk);
      drive(s, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1;
      chk("fault_clear", 32'(mfv[s]), 32'd0);
      chk("fault_rdata", rdv[s], prev);
      return;
    end
    chk("req_stall", 32'(stv[s]), 32'd1);
    chk("req_fault", 32'(mfv[s]), 32'd0);
    for (int k = 1; k <= WS[s] + 1; k++) begin
      @(negedge clk);
      if (!hold) scramble(s);
      #1;
      chk("access_stall", 32'(stv[s]), 32'd1);
      chk("access_rdata", rdv[s], prev);
    end
    widx = int'(a[7:2]);
    lane = int'(a[1:0]);
    if (wr) begin
      if (by) mem_m[s][widx][lane*8 +: 8] = d[7:0];
      else    mem_m[s][widx] = d;
    end else begin
      rd_m[s] = by ? {24'b0, mem_m[s][widx][lane*8 +: 8]} : mem_m[s][widx];
    end
    @(negedge clk);
    if (!hold) scramble(s);
    #1;
    chk("done_stall", 32'(stv[s]), 32'd0);
    chk("done_fault", 32'(mfv[s]), 32'd0);
    chk("done_rdata", rdv[s], rd_m[s]);
    if (!hold) drive(s, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    for (int s = 0; s < 2; s++) begin
      drive(s, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      rd_m[s] = 32'd0;
    end

    // Reset state
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_rdata", rdv[s], 32'd0);
      chk("reset_stall", 32'(stv[s]), 32'd0);
      chk("reset_fault", 32'(mfv[s]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Give every RAM word a known value
    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        op(s, 1'b0, 1'b1, 1'b0, 32'(w * 4), $urandom, 1'b0);

    // Word store then load
    op(1, 1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    op(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("tp_word_load", rdv[1], 32'hDEADBEEF);

    // Byte store into lane 2, then word and byte loads
    op(1, 1'b0, 1'b1, 1'b1, 32'h12, 32'h000000A5, 1'b0);
    op(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("tp_byte_merge", rdv[1], 32'hDEA5BEEF);
    op(1, 1'b1, 1'b0, 1'b1, 32'h13, 32'h0, 1'b0);
    chk("tp_byte_load", rdv[1], 32'h000000DE);

    // Misaligned and out-of-range requests leave RAM alone
    op(1, 1'b1, 1'b0, 1'b0, 32'h06, 32'h0, 1'b0);
    op(1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h55555555, 1'b0);
    op(1, 1'b0, 1'b1, 1'b0, 32'h11, 32'h66666666, 1'b0);
    op(1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("tp_fault_noop", rdv[1], 32'hDEA5BEEF);
    op(1, 1'b1, 1'b0, 1'b0, 32'h04, 32'h0, 1'b0);
    op(1, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0, 1'b0);

    // Reset while a store is in ACCESS: store must not commit
    @(negedge clk);
    drive(1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678);
    #1;
    chk("rst_req_stall", 32'(stv[1]), 32'd1);
    @(negedge clk);
    #1;
    chk("rst_access_stall", 32'(stv[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stv[1]), 32'd0);
    chk("rst_rdata", rdv[1], 32'd0);
    chk("rst_rdata_other", rdv[0], 32'd0);
    rd_m[0] = 32'd0;
    rd_m[1] = 32'd0;
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    rst_n = 1'b1;
    op(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0);

    // Simultaneous read and write is a store
    op(1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    op(1, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0000CAFE, 1'b0);
    op(1, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 1'b0);
    chk("tp_rw_store", rdv[1], 32'h0000CAFE);

    // Zero wait states, loads held asserted across DONE
    op(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'hA1B2C3D4, 1'b0);
    op(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    op(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    op(0, 1'b1, 1'b0, 1'b1, 32'h11, 32'h0, 1'b1);
    chk("tp_ws0_byte", rdv[0], 32'h000000C3);
    op(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Random traffic on both instances
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 150; n++) begin
        a = 32'($urandom_range(0, 263));
        if ($urandom_range(0, 9) == 0) a = $urandom;
        op(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           a, $urandom, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
